mem_arbiter: RTL
================

# mem_arbiter

Sequencing controller and two-port arbiter for the byte-array main memory block (`mem`). It accepts block-granular read/write requests from two requesters (port 0: cache refill/miss path, port 1: write-back path) and grants one at a time. It inserts a programmable access latency to model DRAM delay, then drives single-cycle `rd_en`/`wr_en` pulses into the memory. For reads it captures the returned block, and for both reads and writes it returns a one-cycle response pulse to the granted requester.

## Interface
- `LATENCY`, default 4: wait cycles inserted between acceptance and memory issue; legal range 0..255.
- `PA_WIDTH`, `BLK_WIDTH`: global widths from `macros.sv`, not parameters of this block. BLK_BYTES = BLK_WIDTH/8.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req0_valid`, `req1_valid`  in  1  request present; must be held stable with its payload until accepted.
- `req0_we`, `req1_we`  in  1  1 = block write, 0 = block read.
- `req0_addr`, `req1_addr`  in  PA_WIDTH  byte address; aligned internally to BLK_BYTES.
- `req0_wdata`, `req1_wdata`  in  BLK_WIDTH  write block.
- `req0_ready`, `req1_ready`  out  1  acceptance; a request is accepted in a cycle where valid && ready.
- `resp0_valid`, `resp1_valid`  out  1  one-cycle completion pulse to the granted port.
- `resp_rdata`  out  BLK_WIDTH  read block, valid while a resp*_valid is high; all zeros for writes.
- `mem_addr`  out  PA_WIDTH  block-aligned address to memory.
- `mem_rd_en`, `mem_wr_en`  out  1  memory strobes; at most one high, for exactly one cycle per request.
- `mem_wr_data`  out  BLK_WIDTH  latched write block.
- `mem_rd_data`  in  BLK_WIDTH  memory read data; registered by the memory one cycle after `mem_rd_en`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, ISSUE, CAPT, RESP.
- IDLE
  - Combinational grant among valid requesters.
  - Only the granted port sees ready=1, and only in IDLE.
  - On acceptance, latch grant id, we, addr & ~(BLK_BYTES-1), and wdata. Load the counter with LATENCY.
  - Next state is WAIT if LATENCY>0, else ISSUE.
- WAIT: decrement the counter each cycle; go to ISSUE in the cycle the counter reaches 1.
- ISSUE: assert `mem_rd_en` (read) or `mem_wr_en` (write) for this single cycle, with `mem_addr` and `mem_wr_data` driven from the latches. Next state CAPT.
- CAPT: for reads, register `mem_rd_data` into the response register; for writes, load zeros. Next state RESP.
- RESP: assert `resp<id>_valid` for one cycle. There is no response backpressure. Next state IDLE.
- `mem_addr` and `mem_wr_data` hold their latched values outside ISSUE. The memory ignores them unless a strobe is high.
- Simultaneous valid on both ports: resolved by the arbitration policy (see Configuration). The loser keeps valid high and is served in a later IDLE.
- Requests arriving while busy are not accepted (ready=0). No queueing.

## Timing
- Acceptance occurs in cycle 0.
- WAIT occupies cycles 1..LATENCY.
- ISSUE is cycle LATENCY+1.
- CAPT is cycle LATENCY+2.
- RESP is cycle LATENCY+3.
- The earliest next acceptance is cycle LATENCY+4, so throughput is one request per LATENCY+4 cycles.
- Reset values: state=IDLE, counter=0, all ready/valid/strobe outputs 0, `resp_rdata`=0, `mem_addr`=0, `mem_wr_data`=0, busy=0, last-grant=1.
- Reset asserted mid-operation aborts the request immediately (asynchronously).
  - Strobes and response are deasserted.
  - An aborted write never reaches memory unless its ISSUE edge had already occurred.
- Outputs `req*_ready` are combinational from state and valid. All other outputs are registered.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the port not granted last.
  - The last-grant register updates on every acceptance.
  - After reset, port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties. The last-grant register is not implemented.

## Test plan
- Bench settings: LATENCY=4 unless noted.
- Port0 write, addr 0x00040, data A5A5…: ready0 in cycle 0, `mem_wr_en` only in cycle 5, `mem_addr`=0x00040, resp0_valid in cycle 7, `resp_rdata`=0.
- Port1 read of 0x00040 after that write: `mem_rd_en` in cycle 5, resp1_valid in cycle 7 with `resp_rdata`=A5A5…; resp0_valid stays 0.
- Both ports valid in the same cycle, repeated 4 times:
  - With MEM_ARB_RR_EN, grants alternate 0,1,0,1.
  - Without it, grants are 0,0,0,0 while port 0 keeps requesting.
- Unaligned read addr 0x00047 drives `mem_addr` = 0x00047 & ~(BLK_BYTES-1). LATENCY=0 gives ISSUE in cycle 1 and resp in cycle 3.
- `rst` pulsed in cycle 2 of a write:
  - All outputs return to reset values asynchronously and `mem_wr_en` never pulses.
  - Memory content at the target address is unchanged.
  - The next request is accepted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port block-request arbiter that sequences latency-delayed rd/wr strobes into mem.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default build uses fixed priority to port 0.
`ifndef PA_WIDTH
`define PA_WIDTH 32
`endif
`ifndef BLK_WIDTH
`define BLK_WIDTH 128
`endif

module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [`PA_WIDTH-1:0]  req0_addr,
  input  logic [`BLK_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [`PA_WIDTH-1:0]  req1_addr,
  input  logic [`BLK_WIDTH-1:0] req1_wdata,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic                  resp1_valid,
  output logic [`BLK_WIDTH-1:0] resp_rdata,
  output logic [`PA_WIDTH-1:0]  mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [`BLK_WIDTH-1:0] mem_wr_data,
  input  logic [`BLK_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);
  // state | meaning
  // IDLE  | arbitrate, accept one request
  // WAIT  | count down the access latency
  // ISSUE | single-cycle rd/wr strobe to memory
  // CAPT  | capture read block (zeros for writes)
  // RESP  | one-cycle response pulse to granted port
  localparam int PA        = `PA_WIDTH;
  localparam int BW        = `BLK_WIDTH;
  localparam int BLK_BYTES = BW / 8;
  localparam logic [PA-1:0] ALIGN_MASK = ~(PA'(BLK_BYTES - 1));

  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, CAPT, RESP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cnt;
  logic          gnt_id;
  logic          lat_we;
  logic          grant;
  logic          accept;
  logic          sel_we;
  logic [PA-1:0] sel_addr;
  logic [BW-1:0] sel_wdata;
  logic          we_nxt;
  logic          rd_en_nxt, wr_en_nxt, resp0_nxt, resp1_nxt, busy_nxt;
`ifdef MEM_ARB_RR_EN
  logic          last_grant;
`endif

  // grant = 1 selects port 1
  always_comb begin
    grant = !req0_valid;
    if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_RR_EN
      grant = !last_grant;
`else
      grant = 1'b0;
`endif
    end
  end

  assign accept    = (state == IDLE) && (grant ? req1_valid : req0_valid);
  assign sel_we    = grant ? req1_we    : req0_we;
  assign sel_addr  = grant ? req1_addr  : req0_addr;
  assign sel_wdata = grant ? req1_wdata : req0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_rd_en   <= rd_en_nxt;
      mem_wr_en   <= wr_en_nxt;
      resp0_valid <= resp0_nxt;
      resp1_valid <= resp1_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY > 0) ? WAIT : ISSUE;
      WAIT:    if (cnt == 8'd1) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // strobes are computed from the next state so they come straight off flops
  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid && grant;
    we_nxt     = accept ? sel_we : lat_we;
    rd_en_nxt  = (state_nxt == ISSUE) && !we_nxt;
    wr_en_nxt  = (state_nxt == ISSUE) && we_nxt;
    resp0_nxt  = (state_nxt == RESP) && !gnt_id;
    resp1_nxt  = (state_nxt == RESP) && gnt_id;
    busy_nxt   = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      gnt_id      <= 1'b0;
      lat_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      resp_rdata  <= '0;
    end else begin
      if (accept) begin
        cnt         <= 8'(LATENCY);
        gnt_id      <= grant;
        lat_we      <= sel_we;
        mem_addr    <= sel_addr & ALIGN_MASK;
        mem_wr_data <= sel_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (state == CAPT) resp_rdata <= lat_we ? '0 : mem_rd_data;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`endif

endmodule
